mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised up/down modulo counter with asynchronous clear, the general-purpose successor to the team's fixed 4-bit free-running counters. It adds width and modulus configuration, enable, direction, synchronous load, wrap-or-saturate behaviour, a terminal-count pulse and a sticky overflow flag. It sits behind the I/O buffers, driving counter state to pads or downstream timing logic.

## Interface
- WIDTH, 4, counter width in bits (2..32)
- RESET_VAL, 0, value of result after reset (must fit WIDTH)
- SATURATE, 0, 0 = wrap at boundary, 1 = hold at boundary

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- limit  in  WIDTH  inclusive upper bound of count range (0..limit)
- clr_ovf  in  1  clears sticky ovf
- result  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered
- ovf  out  1  sticky boundary-hit flag, registered

## Operation
- Reset: result = RESET_VAL, tc = 0, ovf = 0, asynchronously on rst high; held while rst high.
- Priority per edge: load > en > hold.
- Load: result <= min(load_val, limit); tc <= 0; ovf unaffected.
- Up count (en=1, up=1): result < limit -> result+1; result >= limit -> boundary event: 0 if SATURATE=0, else limit.
- Down count (en=1, up=0): result > 0 -> result-1, but result > limit -> limit (re-clamp, not a boundary event); result == 0 -> boundary event: limit if SATURATE=0, else 0.
- limit = 0: every enabled count is a boundary event; result stays 0.
- en=0, load=0: result holds, tc <= 0.
- tc <= 1 only on an edge with a boundary event; otherwise 0. In saturate mode, tc pulses on every enabled count attempted at the boundary.
- ovf <= 1 on any boundary event; clr_ovf clears it; simultaneous boundary event and clr_ovf -> ovf = 1 (set wins).
- All arithmetic in WIDTH bits; no carry-out beyond the boundary logic; limit may change any cycle and takes effect immediately on the next edge.

## Timing
- Single clock domain; all outputs registered; no combinational input-to-output path.
- Latency: inputs sampled at edge N appear on result/tc/ovf after edge N.
- tc is exactly one cycle wide per boundary event; consecutive boundary events give consecutive tc cycles.
- Reset asserted mid-count: outputs go to reset values without waiting for clk; first count after deassertion occurs on the first edge with en=1 (or load=1) after rst falls.
- rst deassertion is expected synchronised externally; no internal synchroniser.

## Structure
- Shared package: direction constants (DIR_DOWN, DIR_UP) and a boundary-mode constant pair (MODE_WRAP, MODE_SAT) used for SATURATE.
- One natural sub-module: mod_counter_next, purely combinational, computing next_result and boundary_event from result, limit, up, SATURATE; the top holds the three registers and priority logic.

## Test plan
- WIDTH=4, limit=9, up, en=1 from reset -> result 0..9, 0; tc high exactly in the cycle result returns to 0; ovf=1 thereafter.
- Same, up=0 from 0 -> result 9, 8, ... 0, 9; tc pulses on each 0->9 transition.
- SATURATE=1, limit=5, up for 8 cycles -> result sticks at 5; tc high on the 3 cycles counting at 5; ovf=1; clr_ovf with no boundary -> ovf=0.
- load=1, load_val=12, limit=9 with en=1 same cycle -> result=9, tc=0 (load wins, clamped).
- result=7, limit lowered to 3, up=1 -> next result 0 with tc=1; down=0 case from 7 -> result 3, tc=0.
- Assert rst mid-count at result=6 between clock edges -> result=RESET_VAL, tc=0, ovf=0 immediately; counting resumes from RESET_VAL after release.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo counter: count direction and boundary mode.
package mod_counter_pkg;

    // Value of the 'up' input for each count direction
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Boundary behaviour selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_next.sv
// Combinational next-count logic: computes the value the counter moves to on an
// enabled count, and whether that count hits the range boundary.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] result,
    input  logic [WIDTH-1:0] limit,
    input  logic             up,
    output logic [WIDTH-1:0] next_result,
    output logic             boundary_event
);

    localparam bit SAT_MODE = (SATURATE == MODE_SAT);

    // Next value for an enabled count; boundary handling depends on the mode
    always_comb begin
        next_result    = result;
        boundary_event = 1'b0;
        if (limit == '0) begin
            // Degenerate single-value range: every count sits on the boundary
            boundary_event = 1'b1;
            next_result    = '0;
        end else if (up == DIR_UP) begin
            if (result < limit) begin
                next_result = result + WIDTH'(1);
            end else begin
                // At or above the limit (limit may have just been lowered)
                boundary_event = 1'b1;
                next_result    = SAT_MODE ? limit : '0;
            end
        end else begin
            if (result == '0) begin
                boundary_event = 1'b1;
                next_result    = SAT_MODE ? '0 : limit;
            end else if (result > limit) begin
                // Limit dropped below the count: pull back into range quietly
                next_result = limit;
            end else begin
                next_result = result - WIDTH'(1);
            end
        end
    end

endmodule : mod_counter_next

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load, enable, wrap/saturate
// boundary handling, a terminal-count pulse and a sticky overflow flag.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0,
    parameter int          SATURATE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] result,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] result_reg;
    logic             tc_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] count_next;
    logic             boundary_event;
    logic [WIDTH-1:0] load_clamped;
    logic             count_boundary;

    mod_counter_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .result         (result_reg),
        .limit          (limit),
        .up             (up),
        .next_result    (count_next),
        .boundary_event (boundary_event)
    );

    // Loaded values are clamped into the current count range
    assign load_clamped   = (load_val > limit) ? limit : load_val;
    // A boundary only counts when a count actually happens (load has priority)
    assign count_boundary = en && !load && boundary_event;

    // Count register and terminal-count pulse: load > enable > hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= RESET_COUNT;
            tc_reg     <= 1'b0;
        end else if (load) begin
            result_reg <= load_clamped;
            tc_reg     <= 1'b0;
        end else if (en) begin
            result_reg <= count_next;
            tc_reg     <= boundary_event;
        end else begin
            tc_reg     <= 1'b0;
        end
    end

    // Sticky overflow: a boundary event wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (count_boundary) begin
            ovf_reg <= 1'b1;
        end else if (clr_ovf) begin
            ovf_reg <= 1'b0;
        end
    end

    assign result = result_reg;
    assign tc     = tc_reg;
    assign ovf    = ovf_reg;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: one wrapping and one saturating instance
// share the same stimulus; each task checks the instances it targets.
module tb_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] limit;
    logic       clr_ovf;

    logic [3:0] w_result;
    logic       w_tc;
    logic       w_ovf;
    logic [3:0] s_result;
    logic       s_tc;
    logic       s_ovf;

    int checks   = 0;
    int failures = 0;

    mod_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(0)) u_wrap (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .clr_ovf  (clr_ovf),
        .result   (w_result),
        .tc       (w_tc),
        .ovf      (w_ovf)
    );

    mod_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(1)) u_sat (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .clr_ovf  (clr_ovf),
        .result   (s_result),
        .tc       (s_tc),
        .ovf      (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and sample 1 time unit after it
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        $display("step %-10s en=%0d up=%0d ld=%0d lim=%0d | wrap r=%0d tc=%0d ovf=%0d | sat r=%0d tc=%0d ovf=%0d",
                 tag, en, up, load, limit, w_result, w_tc, w_ovf, s_result, s_tc, s_ovf);
    endtask

    // Load a value and clear ovf in the same cycle (load never sets ovf)
    task automatic preset(input logic [3:0] val, input logic [3:0] lim);
        en = 1'b0; load = 1'b1; load_val = val; limit = lim; clr_ovf = 1'b1;
        step("preset");
        load = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (w_result !== 4'd0 || w_tc !== 1'b0 || w_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_wrap got r=%0d tc=%0d ovf=%0d exp r=0 tc=0 ovf=0", w_result, w_tc, w_ovf);
        end
        checks++;
        if (s_result !== 4'd0 || s_tc !== 1'b0 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_sat got r=%0d tc=%0d ovf=%0d exp r=0 tc=0 ovf=0", s_result, s_tc, s_ovf);
        end
        en = 1'b1; up = 1'b1; limit = 4'd9;
        step("rst_held");
        checks++;
        if (w_result !== 4'd0 || s_result !== 4'd0) begin
            failures++;
            $display("FAIL reset_held got wrap=%0d sat=%0d exp 0", w_result, s_result);
        end
        en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_w;
        logic [3:0] exp_s;
        en = 1'b1; up = 1'b1; limit = 4'd9;
        for (int i = 1; i <= 12; i++) begin
            step("up");
            exp_w = 4'(i % 10);
            exp_s = (i <= 5) ? 4'(i) : 4'd5;
            checks++;
            if (w_result !== exp_w || w_tc !== (i == 10) || w_ovf !== (i >= 10)) begin
                failures++;
                $display("FAIL wrap_up i=%0d got r=%0d tc=%0d ovf=%0d exp r=%0d tc=%0d ovf=%0d",
                         i, w_result, w_tc, w_ovf, exp_w, (i == 10), (i >= 10));
            end
        end
        // Saturating instance saw limit 9 as well: counted 0..9 then sat at 9
        exp_s = 4'd9;
        checks++;
        if (s_result !== exp_s || s_tc !== 1'b1 || s_ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_up9 got r=%0d tc=%0d ovf=%0d exp r=9 tc=1 ovf=1", s_result, s_tc, s_ovf);
        end
    endtask

    task automatic test_wrap_down();
        logic [3:0] exp_w;
        preset(4'd0, 4'd9);
        checks++;
        if (w_ovf !== 1'b0 || s_ovf !== 1'b0 || w_result !== 4'd0) begin
            failures++;
            $display("FAIL preset_clr got wrap r=%0d ovf=%0d sat ovf=%0d exp r=0 ovf=0", w_result, w_ovf, s_ovf);
        end
        en = 1'b1; up = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            step("down");
            exp_w = 4'((10 - (i % 10)) % 10);
            checks++;
            if (w_result !== exp_w || w_tc !== ((i % 10) == 1) || w_ovf !== 1'b1) begin
                failures++;
                $display("FAIL wrap_down i=%0d got r=%0d tc=%0d ovf=%0d exp r=%0d tc=%0d ovf=1",
                         i, w_result, w_tc, w_ovf, exp_w, ((i % 10) == 1));
            end
            checks++;
            if (s_result !== 4'd0 || s_tc !== 1'b1) begin
                failures++;
                $display("FAIL sat_down0 i=%0d got r=%0d tc=%0d exp r=0 tc=1", i, s_result, s_tc);
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_s;
        preset(4'd0, 4'd5);
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step("sat_up");
            exp_s = (i <= 5) ? 4'(i) : 4'd5;
            checks++;
            if (s_result !== exp_s || s_tc !== (i >= 6) || s_ovf !== (i >= 6)) begin
                failures++;
                $display("FAIL sat_up i=%0d got r=%0d tc=%0d ovf=%0d exp r=%0d tc=%0d ovf=%0d",
                         i, s_result, s_tc, s_ovf, exp_s, (i >= 6), (i >= 6));
            end
        end
        en = 1'b0; clr_ovf = 1'b1;
        step("clr_ovf");
        checks++;
        if (s_ovf !== 1'b0 || s_tc !== 1'b0 || s_result !== 4'd5) begin
            failures++;
            $display("FAIL sat_clr got r=%0d tc=%0d ovf=%0d exp r=5 tc=0 ovf=0", s_result, s_tc, s_ovf);
        end
        en = 1'b1;
        step("set_wins");
        checks++;
        if (s_ovf !== 1'b1 || s_tc !== 1'b1 || s_result !== 4'd5) begin
            failures++;
            $display("FAIL sat_set_wins got r=%0d tc=%0d ovf=%0d exp r=5 tc=1 ovf=1", s_result, s_tc, s_ovf);
        end
        clr_ovf = 1'b0;
    endtask

    task automatic test_load_clamp();
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd12; limit = 4'd9;
        step("load12");
        load = 1'b0;
        checks++;
        if (w_result !== 4'd9 || w_tc !== 1'b0 || s_result !== 4'd9 || s_tc !== 1'b0) begin
            failures++;
            $display("FAIL load_clamp got wrap r=%0d tc=%0d sat r=%0d tc=%0d exp r=9 tc=0",
                     w_result, w_tc, s_result, s_tc);
        end
        checks++;
        if (s_ovf !== 1'b1) begin
            failures++;
            $display("FAIL load_keeps_ovf got ovf=%0d exp 1", s_ovf);
        end
    endtask

    task automatic test_limit_change();
        preset(4'd7, 4'd9);
        en = 1'b1; up = 1'b1; limit = 4'd3;
        step("lim3_up");
        checks++;
        if (w_result !== 4'd0 || w_tc !== 1'b1 || s_result !== 4'd3 || s_tc !== 1'b1) begin
            failures++;
            $display("FAIL limit_up got wrap r=%0d tc=%0d sat r=%0d tc=%0d exp wrap 0/1 sat 3/1",
                     w_result, w_tc, s_result, s_tc);
        end
        preset(4'd7, 4'd9);
        en = 1'b1; up = 1'b0; limit = 4'd3;
        step("lim3_dn");
        checks++;
        if (w_result !== 4'd3 || w_tc !== 1'b0 || s_result !== 4'd3 || s_tc !== 1'b0 ||
            w_ovf !== 1'b0 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL limit_down got wrap r=%0d tc=%0d ovf=%0d sat r=%0d tc=%0d ovf=%0d exp r=3 tc=0 ovf=0",
                     w_result, w_tc, w_ovf, s_result, s_tc, s_ovf);
        end
    endtask

    task automatic test_limit_zero();
        preset(4'd0, 4'd0);
        en = 1'b1; up = 1'b1;
        step("lim0_up");
        checks++;
        if (w_result !== 4'd0 || w_tc !== 1'b1 || s_result !== 4'd0 || s_tc !== 1'b1) begin
            failures++;
            $display("FAIL limit0_up got wrap r=%0d tc=%0d sat r=%0d tc=%0d exp r=0 tc=1",
                     w_result, w_tc, s_result, s_tc);
        end
        up = 1'b0;
        step("lim0_dn");
        checks++;
        if (w_result !== 4'd0 || w_tc !== 1'b1 || w_ovf !== 1'b1 || s_tc !== 1'b1 || s_ovf !== 1'b1) begin
            failures++;
            $display("FAIL limit0_down got wrap r=%0d tc=%0d ovf=%0d sat tc=%0d ovf=%0d exp r=0 tc=1 ovf=1",
                     w_result, w_tc, w_ovf, s_tc, s_ovf);
        end
    endtask

    task automatic test_back_to_back();
        // Counts 0..6 without clearing ovf, which is left set by the previous task
        load = 1'b1; load_val = 4'd0; limit = 4'd9; en = 1'b0;
        step("ld0");
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 6; i++) step("run");
        checks++;
        if (w_result !== 4'd6 || s_result !== 4'd6 || w_ovf !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst got wrap r=%0d ovf=%0d sat r=%0d exp r=6 ovf=1", w_result, w_ovf, s_result);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (w_result !== 4'd0 || w_tc !== 1'b0 || w_ovf !== 1'b0 ||
            s_result !== 4'd0 || s_tc !== 1'b0 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL async_rst got wrap r=%0d tc=%0d ovf=%0d sat r=%0d tc=%0d ovf=%0d exp all 0",
                     w_result, w_tc, w_ovf, s_result, s_tc, s_ovf);
        end
        step("rst_hi");
        #2 rst = 1'b0;
        step("resume");
        checks++;
        if (w_result !== 4'd1 || s_result !== 4'd1 || w_tc !== 1'b0) begin
            failures++;
            $display("FAIL resume got wrap r=%0d tc=%0d sat r=%0d exp r=1 tc=0", w_result, w_tc, s_result);
        end
        en = 1'b0;
        step("hold");
        checks++;
        if (w_result !== 4'd1 || w_tc !== 1'b0 || s_result !== 4'd1) begin
            failures++;
            $display("FAIL hold got wrap r=%0d tc=%0d sat r=%0d exp r=1 tc=0", w_result, w_tc, s_result);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        load_val = 4'd0; limit = 4'd9; clr_ovf = 1'b0;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load_clamp();
        test_limit_change();
        test_limit_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod_counter
